// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / host side and the receive FIFO.
// Threshold signals exist only when UART_RX_FIFO_THRESHOLD_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) ();
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  data_valid;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  parity_error;
  logic                  frame_error;
  logic                  rd_en;
  logic                  overrun_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_parity_error;
  logic                  rd_frame_error;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overrun;
`ifdef UART_RX_FIFO_THRESHOLD_EN
  logic [ADDR_WIDTH:0]   rx_threshold;
  logic                  rx_threshold_hit;

  modport master (
    output data_valid, parallel_data, parity_error, frame_error,
    output rd_en, overrun_clr, rx_threshold,
    input  rd_data, rd_parity_error, rd_frame_error, rd_valid,
    input  empty, full, count, overrun, rx_threshold_hit
  );

  modport slave (
    input  data_valid, parallel_data, parity_error, frame_error,
    input  rd_en, overrun_clr, rx_threshold,
    output rd_data, rd_parity_error, rd_frame_error, rd_valid,
    output empty, full, count, overrun, rx_threshold_hit
  );
`else
  modport master (
    output data_valid, parallel_data, parity_error, frame_error,
    output rd_en, overrun_clr,
    input  rd_data, rd_parity_error, rd_frame_error, rd_valid,
    input  empty, full, count, overrun
  );

  modport slave (
    input  data_valid, parallel_data, parity_error, frame_error,
    input  rd_en, overrun_clr,
    output rd_data, rd_parity_error, rd_frame_error, rd_valid,
    output empty, full, count, overrun
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO storing {frame_error, parity_error, data} per character.
// Optional fill threshold flag built when UART_RX_FIFO_THRESHOLD_EN is defined.
module uart_rx_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic            UCLK,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH+1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_parity_error;
  logic                  r_rd_frame_error;
  logic                  r_rd_valid;
  logic                  r_overrun;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_drop;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = bus.rd_en && !w_empty;
  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign w_wr_acc = bus.data_valid && (!w_full || w_rd_acc);
  assign w_drop   = bus.data_valid && w_full && !w_rd_acc;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset; only pointers and flags are.
  always_ff @(posedge UCLK) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= {bus.frame_error, bus.parity_error, bus.parallel_data};
  end

  always_ff @(posedge UCLK) begin
    if (!reset) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_rd_data         <= '0;
      r_rd_parity_error <= 1'b0;
      r_rd_frame_error  <= 1'b0;
      r_rd_valid        <= 1'b0;
      r_overrun         <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        {r_rd_frame_error, r_rd_parity_error, r_rd_data} <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_rd_acc;
      r_count    <= w_count_nxt;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)
        r_overrun <= 1'b1;
      else if (bus.overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  assign bus.rd_data         = r_rd_data;
  assign bus.rd_parity_error = r_rd_parity_error;
  assign bus.rd_frame_error  = r_rd_frame_error;
  assign bus.rd_valid        = r_rd_valid;
  assign bus.count           = r_count;
  assign bus.empty           = w_empty;
  assign bus.full            = w_full;
  assign bus.overrun         = r_overrun;

`ifdef UART_RX_FIFO_THRESHOLD_EN
  logic r_thr_hit;

  always_ff @(posedge UCLK) begin
    if (!reset)
      r_thr_hit <= 1'b0;
    else
      r_thr_hit <= (bus.rx_threshold != '0) && (w_count_nxt >= bus.rx_threshold);
  end

  assign bus.rx_threshold_hit = r_thr_hit;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random run
// compared against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic UCLK  = 1'b0;
  logic reset = 1'b0;
  always #5 UCLK = ~UCLK;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .UCLK  (UCLK),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored entries plus last popped entry and flags.
  logic [DW+1:0] q [$];
  logic [DW+1:0] m_rd;
  logic          m_rv;
  logic          m_ovr;

  function automatic logic [DW+1:0] dut_rd();
    return {bus.rd_frame_error, bus.rd_parity_error, bus.rd_data};
  endfunction

  task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic pe,
                       input logic fe, input logic rd, input logic clr);
    logic rd_ok, wr_ok;
    @(negedge UCLK);
    bus.data_valid    = dv;
    bus.parallel_data = d;
    bus.parity_error  = pe;
    bus.frame_error   = fe;
    bus.rd_en         = rd;
    bus.overrun_clr   = clr;
    @(posedge UCLK);
    rd_ok = rd && (q.size() != 0);
    wr_ok = dv && ((q.size() < DEPTH) || rd_ok);
    m_rv  = rd_ok;
    if (rd_ok) m_rd = q.pop_front();
    if (wr_ok) q.push_back({fe, pe, d});
    if (dv && !wr_ok) m_ovr = 1'b1;
    else if (clr)     m_ovr = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge UCLK);
    reset             = 1'b0;
    bus.data_valid    = 1'b0;
    bus.parallel_data = '0;
    bus.parity_error  = 1'b0;
    bus.frame_error   = 1'b0;
    bus.rd_en         = 1'b0;
    bus.overrun_clr   = 1'b0;
    repeat (2) @(posedge UCLK);
    @(negedge UCLK);
    reset = 1'b1;
    q.delete();
    m_rd  = '0;
    m_rv  = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) cycle(0, 8'h00, 0, 0, 0, 0);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.full); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", bus.overrun); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", bus.rd_valid); end
    checks++; if (dut_rd() !== '0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", dut_rd()); end
  endtask

  task automatic test_single();
    cycle(1, 8'hA5, 0, 0, 0, 0);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.count); end
    cycle(0, 8'h00, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_no_valid got %0b want 0", bus.rd_valid); end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %0b want 1", bus.rd_valid); end
    checks++; if (dut_rd() !== 10'h0A5) begin errors++; $display("FAIL single_rd_entry got %0h want 0a5", dut_rd()); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty got %0b want 1", bus.empty); end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got %0b want 0", bus.rd_valid); end
    checks++; if (dut_rd() !== 10'h0A5) begin errors++; $display("FAIL single_rd_hold got %0h want 0a5", dut_rd()); end
  endtask

  task automatic test_errors();
    cycle(1, 8'h3C, 1, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    cycle(1, 8'h7E, 0, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (dut_rd() !== 10'h13C) begin errors++; $display("FAIL errors_first got %0h want 13c", dut_rd()); end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (dut_rd() !== 10'h27E) begin errors++; $display("FAIL errors_second got %0h want 27e", dut_rd()); end
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL errors_valid got %0b want 1", bus.rd_valid); end
  endtask

  task automatic test_full_overrun();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 8'(i), 0, 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0, 0);
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b want 1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", bus.count); end
    cycle(1, 8'h09, 0, 0, 0, 0);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %0b want 1", bus.overrun); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL overrun_count got %0d want 8", bus.count); end
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 8'h00, 0, 0, 1, 0);
      checks++; if (dut_rd() !== 10'(i)) begin errors++; $display("FAIL full_drain[%0d] got %0h want %0h", i, dut_rd(), i); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %0b want 1", bus.empty); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b want 1", bus.overrun); end
    cycle(0, 8'h00, 0, 0, 0, 1);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %0b want 0", bus.overrun); end
  endtask

  task automatic test_full_simul();
    logic [DW+1:0] first;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      cycle(0, 8'h00, 0, 0, 0, 0);
    end
    first = q[0];
    cycle(1, 8'h55, 0, 0, 1, 0);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL simul_full_count got %0d want 8", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL simul_full_overrun got %0b want 0", bus.overrun); end
    checks++; if (dut_rd() !== first) begin errors++; $display("FAIL simul_full_oldest got %0h want %0h", dut_rd(), first); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 0, 0, 1, 0);
      checks++; if (dut_rd() !== m_rd) begin errors++; $display("FAIL simul_full_drain[%0d] got %0h want %0h", i, dut_rd(), m_rd); end
    end
    checks++; if (dut_rd() !== 10'h055) begin errors++; $display("FAIL simul_full_last got %0h want 055", dut_rd()); end
  endtask

  task automatic test_empty_wrap();
    cycle(1, 8'h11, 0, 0, 1, 0);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_simul_valid got %0b want 0", bus.rd_valid); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL empty_simul_count got %0d want 1", bus.count); end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'($urandom), 1'($urandom), 1'($urandom), 1, 0);
      checks++; if (dut_rd() !== m_rd || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL wrap_pair[%0d] got %0h/%0b want %0h/1", i, dut_rd(), bus.rd_valid, m_rd); end
      checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 1", i, bus.count); end
      cycle(0, 8'h00, 0, 0, 0, 0);
    end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++; if (dut_rd() !== m_rd || bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_final got %0h/%0b want %0h/1", dut_rd(), bus.empty, m_rd); end
  endtask

  task automatic test_random();
    logic last_dv = 1'b0;
    logic dv, rd, clr;
    for (int n = 0; n < 400; n++) begin
      dv  = !last_dv && ($urandom_range(0, 99) < ((n % 100) < 60 ? 90 : 30));
      rd  = $urandom_range(0, 99) < ((n % 100) < 60 ? 20 : 70);
      clr = $urandom_range(0, 99) < 10;
      last_dv = dv;
      cycle(dv, 8'($urandom), 1'($urandom), 1'($urandom), rd, clr);
      checks++; if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", n, bus.count, q.size()); end
      checks++; if (bus.rd_valid !== m_rv) begin errors++; $display("FAIL rand_rd_valid[%0d] got %0b want %0b", n, bus.rd_valid, m_rv); end
      checks++; if (dut_rd() !== m_rd) begin errors++; $display("FAIL rand_rd_entry[%0d] got %0h want %0h", n, dut_rd(), m_rd); end
      checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun[%0d] got %0b want %0b", n, bus.overrun, m_ovr); end
      checks++; if (bus.full !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_flags[%0d] got full=%0b empty=%0b want size %0d", n, bus.full, bus.empty, q.size()); end
    end
  endtask

  initial begin
`ifdef UART_RX_FIFO_THRESHOLD_EN
    bus.rx_threshold = '0;
`endif
    test_reset();
    test_single();
    test_errors();
    test_full_overrun();
    test_full_simul();
    test_empty_wrap();
    apply_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
